traffic_phase_scheduler: RTL and testbench
==========================================

Name: traffic_phase_scheduler

Overview:
- Sequences green time between the two approaches, A and B, of a two-road intersection.
- Drives the same 3-bit A/B lamp buses as the existing traffic_light block.
- Adds vehicle-sensor demand, min/max green limits and emergency preemption.
- Sits above the lamp drivers as the sole source of lamp state; one instance per intersection.

Parameters:
GREEN_MIN, 5, minimum green duration in clock cycles (not applied under preemption)
GREEN_MAX, 20, maximum green duration when the opposing road has demand
YELLOW_T, 2, yellow duration in cycles
ALLRED_T, 1, all-red clearance duration in cycles
TW, 5, timer width; must satisfy 2^TW > max(GREEN_MAX, YELLOW_T, ALLRED_T)

Ports:
clock  input  1  system clock; all state is updated on its rising edge
reset  input  1  asynchronous reset, active-high
sense_a  input  1  vehicle present on road A (level, synchronous to clock)
sense_b  input  1  vehicle present on road B
preempt  input  1  emergency preemption request (level)
preempt_dir  input  1  preempted direction: 0 = road A, 1 = road B
A  output  3  road A lamps {red, yellow, green}: 100 = red, 010 = yellow, 001 = green
B  output  3  road B lamps, same encoding
phase  output  3  current state encoding, for debug and status

Behaviour:
- The clock is the only clock. reset is asynchronous and active-high.
- Reset value, applied immediately without waiting for a clock edge: state INIT, timer 0, A = 100, B = 100, phase = 0, last_green = B.
- A, B and phase are registered outputs decoded from the state register. They change only on the clock edge that enters a new state.
- States and phase codes: INIT = 0, A_GRN = 1, A_YEL = 2, AR_AB = 3, B_GRN = 4, B_YEL = 5, AR_BA = 6.
- Timer: cleared to 0 on every state entry and incremented each cycle while in the state. It saturates at all ones.
- A state of duration N is left on the edge where timer == N-1, so the state lasts exactly N cycles.
- INIT: hold for ALLRED_T cycles, then go to A_GRN. If preempt = 1 with preempt_dir = 1, go to B_GRN instead.
- X_GRN, where X is the current green road and Y the opposing road:
  - If preempt = 1 and preempt_dir selects Y: go to X_YEL on the next edge, regardless of the timer or GREEN_MIN.
  - Else if preempt = 1 and preempt_dir selects X: hold green; GREEN_MAX is ignored.
  - Else if timer < GREEN_MIN-1: hold green.
  - Else if sense_Y = 0: rest in green indefinitely.
  - Else if sense_X = 0: go to X_YEL.
  - Else go to X_YEL when timer == GREEN_MAX-1.
- X_YEL: lasts exactly YELLOW_T cycles. Preempt has no effect on yellow duration. Then go to the all-red state.
- AR_AB / AR_BA: lasts exactly ALLRED_T cycles. Record last_green = X. Next green:
  - preempt_dir's road if preempt = 1 (this may return green to X);
  - otherwise the opposite of last_green.
- Transitions go only green → yellow → all-red → green. Red never changes directly to yellow, and green never changes directly to red.
- Invariants, checked by assertions:
  - A and B are always one-hot.
  - A and B are never both non-red in the same cycle.
  - Every green lasts at least GREEN_MIN cycles unless a preempt toward the opposing road was present.
- Simultaneous events:
  - Preempt toward Y at the same edge as natural GREEN_MAX expiry: result is X_YEL (same target).
  - Preempt deasserted during yellow or all-red: the decision uses the preempt value sampled at the all-red exit edge.
- Reset asserted in any state forces A = B = 100 immediately, then resumes through INIT.

Decomposition:
- Shared package traffic_pkg:
  - lamp encodings LAMP_RED = 3'b100, LAMP_YEL = 3'b010, LAMP_GRN = 3'b001;
  - state enum with the phase codes above;
  - DIR_A / DIR_B constants.
- One natural sub-module: phase_timer.
  - TW-bit up-counter with synchronous clear and saturation.
  - Output done = (count == limit-1), where limit is a runtime input.
  - The FSM selects limit per state: GREEN_MIN, GREEN_MAX, YELLOW_T or ALLRED_T.

Test Plan:
1. Reset pulse, sensors 0, preempt 0 → A = B = 100 for 1 cycle, then A = 001, B = 100 held for 40 cycles with no change.
2. sense_b = 1, sense_a = 0 from reset → A green exactly 5 cycles, A = 010 for 2, A = B = 100 for 1, then B = 001 resting.
3. sense_a = sense_b = 1 → A green 20, yellow 2, all-red 1, B green 20, yellow 2, all-red 1. Period 46 cycles, repeating.
4. preempt = 1, preempt_dir = 1 on the 2nd A-green cycle → A = 010 next edge, 2 cycles yellow, 1 all-red, then B = 001. B is held past 20 cycles with sense_a = 1 while preempt stays 1.
5. reset asserted mid A_YEL, between clock edges → A = B = 100 and phase = 0 before the next edge. After release, INIT 1 cycle, then A green.
6. preempt_dir = 0 asserted during B_YEL → yellow still lasts 2 cycles, all-red 1 cycle, then A = 001. No both-non-red cycle occurs at any point.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler: lamp codes,
// road identifiers, FSM states (their encodings are the visible phase codes)
// and lamp decode helpers.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    A_GRN = 3'd1,
    A_YEL = 3'd2,
    AR_AB = 3'd3,
    B_GRN = 3'd4,
    B_YEL = 3'd5,
    AR_BA = 3'd6
  } state_t;

  // Road A lamp pattern shown while in state s.
  function automatic logic [2:0] lamp_a(state_t s);
    case (s)
      A_GRN:   return LAMP_GRN;
      A_YEL:   return LAMP_YEL;
      default: return LAMP_RED;
    endcase
  endfunction

  // Road B lamp pattern shown while in state s.
  function automatic logic [2:0] lamp_b(state_t s);
    case (s)
      B_GRN:   return LAMP_GRN;
      B_YEL:   return LAMP_YEL;
      default: return LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-state dwell counter: cleared on state entry, counts up once per cycle,
// sticks at all ones. done flags the last cycle of a state lasting limit cycles.
module phase_timer #(
  parameter int TW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic [TW-1:0] limit,
  output logic [TW-1:0] count,
  output logic          done
);

  // Saturating up-counter with synchronous clear.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == limit - 1'b1);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase sequencer. Walks green -> yellow -> all-red for
// roads A and B under sensor demand, min/max green limits and emergency
// preemption. Lamp buses and phase are registered copies of the next state so
// they change only on the edge that enters a new state.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int TW        = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sense_a,
  input  logic       sense_b,
  input  logic       preempt,
  input  logic       preempt_dir,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic [2:0] phase
);

  localparam logic [TW-1:0] GMIN_LAST = TW'(GREEN_MIN - 1);

  state_t        state;
  state_t        next_state;
  logic          last_green;
  logic          next_dir;
  logic          clear;
  logic          done;
  logic          min_met;
  logic [TW-1:0] limit;
  logic [TW-1:0] count;

  phase_timer #(.TW(TW)) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .limit (limit),
    .count (count),
    .done  (done)
  );

  assign min_met  = (count >= GMIN_LAST);
  // After all-red, an active preempt picks the road; otherwise alternate.
  assign next_dir = preempt ? preempt_dir : ~last_green;
  assign clear    = (next_state != state);

  // Next-state and per-state timer limit selection.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    next_state = state;
    limit      = TW'(ALLRED_T);
    case (state)
      INIT, AR_AB, AR_BA: begin
        limit = TW'(ALLRED_T);
        if (done) next_state = (next_dir == DIR_B) ? B_GRN : A_GRN;
      end
      A_GRN: begin
        limit = TW'(GREEN_MAX);
        if (preempt && preempt_dir == DIR_B)     next_state = A_YEL;
        else if (preempt)                        next_state = A_GRN;
        else if (!min_met || !sense_b)           next_state = A_GRN;
        else if (!sense_a || done)               next_state = A_YEL;
      end
      B_GRN: begin
        limit = TW'(GREEN_MAX);
        if (preempt && preempt_dir == DIR_A)     next_state = B_YEL;
        else if (preempt)                        next_state = B_GRN;
        else if (!min_met || !sense_a)           next_state = B_GRN;
        else if (!sense_b || done)               next_state = B_YEL;
      end
      A_YEL: begin
        limit = TW'(YELLOW_T);
        if (done) next_state = AR_AB;
      end
      B_YEL: begin
        limit = TW'(YELLOW_T);
        if (done) next_state = AR_BA;
      end
      default: next_state = INIT;
    endcase
  end

  // State register plus registered lamp/phase decode and last-green memory.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      A          <= LAMP_RED;
      B          <= LAMP_RED;
      phase      <= 3'd0;
      last_green <= DIR_B;
    end else begin
      state <= next_state;
      A     <= lamp_a(next_state);
      B     <= lamp_b(next_state);
      phase <= next_state;
      if (next_state == A_GRN)      last_green <= DIR_A;
      else if (next_state == B_GRN) last_green <= DIR_B;
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: directed scenarios followed
// by randomized inputs, all compared cycle by cycle against a road/phase-kind
// reference model, plus lamp safety and minimum-green invariants.
module tb_traffic_phase_scheduler;

  localparam int GREEN_MIN = 5;
  localparam int GREEN_MAX = 20;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int TW        = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sense_a = 1'b0;
  logic       sense_b = 1'b0;
  logic       preempt = 1'b0;
  logic       preempt_dir = 1'b0;
  logic [2:0] A;
  logic [2:0] B;
  logic [2:0] phase;

  always #5 clock = ~clock;

  traffic_phase_scheduler #(
    .GREEN_MIN (GREEN_MIN),
    .GREEN_MAX (GREEN_MAX),
    .YELLOW_T  (YELLOW_T),
    .ALLRED_T  (ALLRED_T),
    .TW        (TW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sense_a     (sense_a),
    .sense_b     (sense_b),
    .preempt     (preempt),
    .preempt_dir (preempt_dir),
    .A           (A),
    .B           (B),
    .phase       (phase)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: phase kind, road holding right-of-way, time in phase.
  typedef enum int {K_INIT, K_GRN, K_YEL, K_RED} kind_t;
  kind_t m_kind;
  int    m_road;     // 0 = A, 1 = B
  int    m_last;     // road that last had green
  int    m_elapsed;

  // Minimum-green invariant tracking, from observed lamps.
  int a_len, b_len;
  bit a_pre, b_pre, a_was_grn, b_was_grn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [2:0] exp_lamp(input int road);
    if (m_road == road && m_kind == K_GRN) return 3'b001;
    if (m_road == road && m_kind == K_YEL) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_phase();
    case (m_kind)
      K_GRN:   return (m_road == 1) ? 3'd4 : 3'd1;
      K_YEL:   return (m_road == 1) ? 3'd5 : 3'd2;
      K_RED:   return (m_road == 1) ? 3'd6 : 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_kind = K_INIT; m_road = 0; m_last = 1; m_elapsed = 0;
    a_len = 0; b_len = 0; a_pre = 0; b_pre = 0; a_was_grn = 0; b_was_grn = 0;
  endtask

  // One clock edge of the intersection rules, using the inputs present at the edge.
  task automatic model_step();
    kind_t nk = m_kind;
    int    nr = m_road;
    bit    sx, sy, go;
    case (m_kind)
      K_INIT, K_RED: if (m_elapsed == ALLRED_T - 1) begin
        nk = K_GRN;
        nr = preempt ? int'(preempt_dir) : 1 - m_last;
      end
      K_GRN: begin
        sx = (m_road == 1) ? sense_b : sense_a;
        sy = (m_road == 1) ? sense_a : sense_b;
        if (preempt && int'(preempt_dir) != m_road) go = 1;
        else if (preempt)                           go = 0;
        else if (m_elapsed < GREEN_MIN - 1)         go = 0;
        else if (!sy)                               go = 0;
        else if (!sx)                               go = 1;
        else                                        go = (m_elapsed == GREEN_MAX - 1);
        if (go) nk = K_YEL;
      end
      K_YEL: if (m_elapsed == YELLOW_T - 1) nk = K_RED;
      default: ;
    endcase
    if (nk != m_kind || nr != m_road) begin
      m_elapsed = 0;
      if (nk == K_GRN) m_last = nr;
    end else begin
      m_elapsed++;
    end
    m_kind = nk;
    m_road = nr;
  endtask

  task automatic compare_outputs();
    check("lamp_a", 32'(A), 32'(exp_lamp(0)));
    check("lamp_b", 32'(B), 32'(exp_lamp(1)));
    check("phase", 32'(phase), 32'(exp_phase()));
    check("a_onehot", 32'($onehot(A)), 32'd1);
    check("b_onehot", 32'($onehot(B)), 32'd1);
    check("both_non_red", 32'(A != 3'b100 && B != 3'b100), 32'd0);
  endtask

  task automatic track_green();
    if (A == 3'b001) a_len++;
    else begin
      if (a_len > 0) check("a_green_min", 32'(a_len >= GREEN_MIN || a_pre), 32'd1);
      a_len = 0; a_pre = 0;
    end
    if (B == 3'b001) b_len++;
    else begin
      if (b_len > 0) check("b_green_min", 32'(b_len >= GREEN_MIN || b_pre), 32'd1);
      b_len = 0; b_pre = 0;
    end
    a_was_grn = (A == 3'b001);
    b_was_grn = (B == 3'b001);
  endtask

  // Advance one clock: step the model at the edge, check at the falling edge.
  task automatic cycle();
    @(posedge clock);
    if (a_was_grn && preempt && preempt_dir == 1'b1) a_pre = 1;
    if (b_was_grn && preempt && preempt_dir == 1'b0) b_pre = 1;
    model_step();
    cyc++;
    @(negedge clock);
    compare_outputs();
    track_green();
  endtask

  // Synchronous-looking reset pulse applied at a falling edge, held n edges.
  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    #1 compare_outputs();
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
      compare_outputs();
    end
    reset = 1'b0;
  endtask

  initial begin
    int t2_exp[10] = '{1, 1, 1, 1, 1, 2, 2, 3, 4, 4};
    int first_a, second_a;
    bit seen_yel;
    logic [2:0] prev_phase;

    model_reset();

    // Idle intersection: A takes green and rests there.
    do_reset(2);
    check("t1_init_phase", 32'(phase), 32'd0);
    repeat (41) cycle();
    check("t1_a_rest", 32'(A), 32'b001);

    // Demand only on B: A gets exactly the minimum green, then hands over.
    sense_b = 1'b1;
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t2_timeline", 32'(phase), 32'(t2_exp[i]));
    end
    repeat (10) cycle();
    check("t2_b_rest", 32'(B), 32'b001);

    // Demand on both roads: full GREEN_MAX cycle, 46-cycle period.
    sense_a = 1'b1;
    sense_b = 1'b1;
    do_reset(1);
    first_a = -1; second_a = -1; prev_phase = phase;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (phase == 3'd1 && prev_phase != 3'd1) begin
        if (first_a < 0) first_a = cyc;
        else if (second_a < 0) second_a = cyc;
      end
      prev_phase = phase;
    end
    check("t3_period", 32'(second_a - first_a), 32'd46);

    // Preempt toward B on the second A-green cycle; B then held past GREEN_MAX.
    sense_a = 1'b1;
    sense_b = 1'b0;
    do_reset(1);
    cycle();
    cycle();
    check("t4_a_green_2nd", 32'(A), 32'b001);
    preempt = 1'b1; preempt_dir = 1'b1;
    cycle();
    check("t4_a_yellow", 32'(A), 32'b010);
    repeat (33) cycle();
    check("t4_b_held", 32'(B), 32'b001);

    // Preempt toward A asserted while B is yellow.
    preempt = 1'b0;
    sense_b = 1'b0;
    seen_yel = 0;
    for (int i = 0; i < 10 && !seen_yel; i++) begin
      cycle();
      if (B == 3'b010) seen_yel = 1;
    end
    check("t6_reached_b_yel", 32'(seen_yel), 32'd1);
    preempt = 1'b1; preempt_dir = 1'b0;
    repeat (4) cycle();
    check("t6_a_green", 32'(A), 32'b001);
    preempt = 1'b0;

    // Asynchronous reset mid A-yellow, between clock edges.
    sense_a = 1'b0;
    sense_b = 1'b1;
    do_reset(1);
    seen_yel = 0;
    for (int i = 0; i < 20 && !seen_yel; i++) begin
      cycle();
      if (A == 3'b010) seen_yel = 1;
    end
    check("t5_reached_a_yel", 32'(seen_yel), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_a", 32'(A), 32'b100);
    check("t5_async_b", 32'(B), 32'b100);
    check("t5_async_phase", 32'(phase), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    compare_outputs();
    cycle();
    check("t5_a_green_after", 32'(phase), 32'd1);

    // Randomized demand, preemption and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) sense_a = ~sense_a;
      if ($urandom_range(7) == 0) sense_b = ~sense_b;
      if ($urandom_range(29) == 0) begin
        preempt     = ~preempt;
        preempt_dir = 1'($urandom_range(1));
      end
      if ($urandom_range(499) == 0) do_reset(1);
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
